fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default `INST_BUFF_DEPTH: number of entries; DEPTH SHALL be >= N and >= FETCH_W, and need not be a power of two.
REQ-002 Parameter N, default `N: maximum number of instructions dispatched per cycle.
REQ-003 Parameter FETCH_W, default `N: maximum number of instructions offered by fetch per cycle.
REQ-004 Ports, in order: name, direction, width, meaning.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_insts  in  INST_PACKET[FETCH_W]  packets offered by fetch; slot 0 is oldest.
- num_offer  in  $clog2(FETCH_W+1)  count of valid packets in in_insts, taken from slot 0 upward.
- num_dispatch  in  $clog2(N+1)  count of packets the consumer takes from out_insts this cycle.
- flush  in  1  discards all contents (mispredict squash).
- out_insts  out  INST_PACKET[N]  oldest entries; slot 0 is the head.
- out_valid  out  N  per-slot valid bit for out_insts.
- num_avail  out  $clog2(N+1)  min(count, N).
- num_accepted  out  $clog2(FETCH_W+1)  packets actually taken from in_insts this cycle.
- free_entries  out  $clog2(DEPTH+1)  DEPTH - count.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- dispatch_err  out  1  sticky flag: over-dispatch occurred.

Function
REQ-005 State SHALL consist of: entries[DEPTH], head, tail (each $clog2(DEPTH) bits), count ($clog2(DEPTH)+1 bits) and the dispatch_err flag.
REQ-006 Pointer advance SHALL wrap explicitly: if ptr + k >= DEPTH, the new value is ptr + k - DEPTH; no modulo on a non-power-of-two DEPTH.
REQ-007 free_entries, full, empty and num_avail SHALL be derived from registered count only.
REQ-008 out_insts[i] SHALL equal entries[head+i wrapped] with out_valid[i]=1 for i < num_avail; otherwise out_insts[i]='0 and out_valid[i]=0.
REQ-009 Effective dispatch (eff_disp) SHALL be min(num_dispatch, num_avail).
REQ-010 If num_dispatch > num_avail and flush=0, dispatch_err SHALL be set on the next edge and SHALL stay set until reset.
REQ-011 num_accepted SHALL be min(num_offer, free_entries) as a combinational output.
REQ-012 Space freed by same-cycle dispatch SHALL NOT be counted in num_accepted, so there is no combinational path from num_dispatch to num_accepted.
REQ-013 On each edge without flush or reset:
- head += eff_disp;
- tail += num_accepted;
- count += num_accepted - eff_disp.
REQ-014 Dispatched slots SHALL be written '0.
REQ-015 in_insts[j] for j < num_accepted SHALL be written to entries[tail+j wrapped].
REQ-016 A slot both freed and written in the same cycle SHALL take the written value. This cannot occur while REQ-012 holds, but the write SHALL still take priority.
REQ-017 There is no bypass: an accepted packet appears on out_insts no earlier than the cycle after acceptance, so latency is 1 cycle.
REQ-018 Flush SHALL have priority over accept and dispatch. On the next edge: head=0, tail=0, count=0, all entries='0. Same-cycle offers are discarded and dispatch_err is not modified.
REQ-019 During a flush cycle, num_accepted SHALL still report min(num_offer, free_entries); fetch ignores it when flush=1.
REQ-020 count SHALL never exceed DEPTH nor underflow, for any input combination.

Reset
REQ-021 On reset=1 at an edge:
- head=0, tail=0, count=0;
- entries='0;
- dispatch_err=0.
REQ-022 Reset SHALL have priority over flush and all other inputs.
REQ-023 In the cycle after reset, outputs SHALL be:
- empty=1, full=0;
- free_entries=DEPTH;
- num_avail=0, out_valid=0, out_insts='0;
- num_accepted=0 when num_offer=0.
REQ-024 Reset asserted mid-operation SHALL discard all contents, identically to power-up reset.

Verification
All scenarios use DEPTH=6, N=2, FETCH_W=4.
REQ-025 Reset: after reset -> empty=1, free_entries=6, num_avail=0, out_valid=2'b00, dispatch_err=0.
REQ-026 Fill and backpressure:
- Cycle 1: offer 4 (A..D), dispatch 0 -> num_accepted=4.
- Cycle 2: offer 4 (E..H) -> num_accepted=2 (E, F).
- Cycle 3: full=1; offer 4 -> num_accepted=0.
- Result: out_insts = {A, B}.
REQ-027 Wrap-around:
- From the full state, dispatch 2 for 2 cycles -> head=4, count=2.
- Then offer 4 (I..L) -> accepted into slots 0..3, tail=4, count=6.
- Subsequent dispatch order: E, F, I, J, K, L.
REQ-028 Simultaneous events:
- count=6, dispatch 2 and offer 4 in the same cycle -> num_accepted=0, next count=4.
- Next cycle, offer 4 -> num_accepted=2.
REQ-029 Over-dispatch: count=1, num_dispatch=2 -> only 1 entry removed, count=0, dispatch_err=1 on the next edge and it stays 1 until reset.
REQ-030 Flush priority: count=3, flush=1 with offer 4 and dispatch 2 -> next cycle count=0, empty=1, free_entries=6, out_valid=0, all entries '0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and dispatch.
// Supports multi-packet accept/dispatch per cycle, flush, and non-power-of-two depth.
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 8
`endif
`ifndef N
`define N 2
`endif

package fetch_queue_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } inst_packet_t;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH   = `INST_BUFF_DEPTH,
   parameter int N       = `N,
   parameter int FETCH_W = `N
) (
   input  logic                         clock,
   input  logic                         reset,
   input  inst_packet_t                 in_insts [FETCH_W],
   input  logic [$clog2(FETCH_W+1)-1:0] num_offer,
   input  logic [$clog2(N+1)-1:0]       num_dispatch,
   input  logic                         flush,
   output inst_packet_t                 out_insts [N],
   output logic [N-1:0]                 out_valid,
   output logic [$clog2(N+1)-1:0]       num_avail,
   output logic [$clog2(FETCH_W+1)-1:0] num_accepted,
   output logic [$clog2(DEPTH+1)-1:0]   free_entries,
   output logic                         full,
   output logic                         empty,
   output logic                         dispatch_err
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(FETCH_W + 1);
   localparam int DW = $clog2(N + 1);
   localparam int FW = $clog2(DEPTH + 1);

   inst_packet_t   entries   [DEPTH];
   inst_packet_t   entries_n [DEPTH];
   logic [PW-1:0]  head, tail;
   logic [CW-1:0]  count;
   logic [DW-1:0]  eff_disp;

   // pointer + k never reaches 2*DEPTH, so one conditional subtract suffices
   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      return (s >= DEPTH) ? PW'(s - DEPTH) : PW'(s);
   endfunction

   always_comb begin
      num_avail    = (count > CW'(N)) ? DW'(N) : DW'(count);
      free_entries = FW'(DEPTH) - FW'(count);
      full         = count == CW'(DEPTH);
      empty        = count == '0;
      num_accepted = (int'(num_offer) > int'(free_entries)) ? OW'(free_entries) : num_offer;
      eff_disp     = (num_dispatch > num_avail) ? num_avail : num_dispatch;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         out_valid[i] = i < int'(num_avail);
         out_insts[i] = out_valid[i] ? entries[wrap(head, i)] : '0;
      end
   end

   // writes come after clears so a written slot wins over a freed one
   always_comb begin
      entries_n = entries;
      for (int i = 0; i < N; i++)
         if (i < int'(eff_disp)) entries_n[wrap(head, i)] = '0;
      for (int j = 0; j < FETCH_W; j++)
         if (j < int'(num_accepted)) entries_n[wrap(tail, j)] = in_insts[j];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         dispatch_err <= 1'b0;
         entries      <= '{default: '0};
      end else if (flush) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         entries      <= '{default: '0};
      end else begin
         head         <= wrap(head, int'(eff_disp));
         tail         <= wrap(tail, int'(num_accepted));
         count        <= count + CW'(num_accepted) - CW'(eff_disp);
         entries      <= entries_n;
         if (num_dispatch > num_avail) dispatch_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   logic         clk = 0;
   logic         reset = 1;
   inst_packet_t in_insts [4];
   logic [2:0]   num_offer = 0;
   logic [1:0]   num_dispatch = 0;
   logic         flush = 0;
   inst_packet_t out_insts [2];
   logic [1:0]   out_valid;
   logic [1:0]   num_avail;
   logic [2:0]   num_accepted;
   logic [2:0]   free_entries;
   logic         full, empty, dispatch_err;

   int checks = 0;
   int errors = 0;
   bit armed = 0;
   inst_packet_t mq[$];
   bit merr = 0;

   fetch_queue #(.DEPTH(6), .N(2), .FETCH_W(4)) dut (
      .clock(clk), .reset(reset), .in_insts(in_insts), .num_offer(num_offer),
      .num_dispatch(num_dispatch), .flush(flush), .out_insts(out_insts),
      .out_valid(out_valid), .num_avail(num_avail), .num_accepted(num_accepted),
      .free_entries(free_entries), .full(full), .empty(empty), .dispatch_err(dispatch_err)
   );

   initial forever #5 clk = ~clk;

   function automatic inst_packet_t mk(input int tag);
      return '{pc: 32'(tag * 4), inst: 32'(tag)};
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int av, acc;
      if (reset) begin
         mq.delete();
         merr = 0;
         armed = 1;
      end else if (flush) begin
         mq.delete();
      end else begin
         av  = imin(mq.size(), 2);
         acc = imin(int'(num_offer), 6 - mq.size());
         if (int'(num_dispatch) > av) merr = 1;
         repeat (imin(int'(num_dispatch), av)) void'(mq.pop_front());
         for (int j = 0; j < acc; j++) mq.push_back(in_insts[j]);
      end
   end

   always @(negedge clk) begin
      int cnt, av;
      inst_packet_t e;
      if (armed) begin
         cnt = mq.size();
         av  = imin(cnt, 2);
         check("num_avail", 64'(num_avail), 64'(av));
         check("free_entries", 64'(free_entries), 64'(6 - cnt));
         check("full", 64'(full), 64'(cnt == 6));
         check("empty", 64'(empty), 64'(cnt == 0));
         check("num_accepted", 64'(num_accepted), 64'(imin(int'(num_offer), 6 - cnt)));
         check("dispatch_err", 64'(dispatch_err), 64'(merr));
         for (int i = 0; i < 2; i++) begin
            e = (i < av) ? mq[i] : '0;
            check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(i < av));
            check($sformatf("out_insts%0d", i), 64'(out_insts[i]), 64'(e));
         end
      end
   end

   task automatic cyc(input int offer, input int disp, input int fl, input int base, input int rs);
      @(posedge clk);
      #1;
      reset        = rs[0];
      flush        = fl[0];
      num_offer    = 3'(offer);
      num_dispatch = 2'(disp);
      for (int j = 0; j < 4; j++) in_insts[j] = mk(base + j);
      #1;
   endtask

   initial begin
      for (int j = 0; j < 4; j++) in_insts[j] = '0;
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_free", 64'(free_entries), 64'(6));
      check("rst_avail", 64'(num_avail), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_err", 64'(dispatch_err), 64'(0));
      cyc(4, 0, 0, 1, 0);
      check("fill1_acc", 64'(num_accepted), 64'(4));
      cyc(4, 0, 0, 5, 0);
      check("fill2_acc", 64'(num_accepted), 64'(2));
      cyc(4, 0, 0, 9, 0);
      check("fill3_full", 64'(full), 64'(1));
      check("fill3_acc", 64'(num_accepted), 64'(0));
      check("fill3_out0", 64'(out_insts[0]), 64'(mk(1)));
      check("fill3_out1", 64'(out_insts[1]), 64'(mk(2)));
      cyc(0, 2, 0, 0, 0);
      cyc(0, 2, 0, 0, 0);
      cyc(4, 0, 0, 20, 0);
      check("wrap_acc", 64'(num_accepted), 64'(4));
      check("wrap_out0", 64'(out_insts[0]), 64'(mk(5)));
      check("wrap_out1", 64'(out_insts[1]), 64'(mk(6)));
      cyc(4, 2, 0, 30, 0);
      check("simul_acc", 64'(num_accepted), 64'(0));
      cyc(4, 0, 0, 40, 0);
      check("simul2_acc", 64'(num_accepted), 64'(2));
      check("order_i", 64'(out_insts[0]), 64'(mk(20)));
      cyc(0, 2, 0, 0, 0);
      cyc(0, 2, 0, 0, 0);
      check("order_k", 64'(out_insts[0]), 64'(mk(22)));
      check("order_l", 64'(out_insts[1]), 64'(mk(23)));
      cyc(0, 1, 0, 0, 0);
      cyc(0, 2, 0, 0, 0);
      check("over_avail", 64'(num_avail), 64'(1));
      check("over_out0", 64'(out_insts[0]), 64'(mk(41)));
      cyc(0, 0, 0, 0, 0);
      check("over_empty", 64'(empty), 64'(1));
      check("over_err", 64'(dispatch_err), 64'(1));
      cyc(3, 0, 0, 50, 0);
      cyc(4, 2, 1, 60, 0);
      check("flush_acc", 64'(num_accepted), 64'(3));
      cyc(0, 0, 0, 0, 0);
      check("flush_empty", 64'(empty), 64'(1));
      check("flush_free", 64'(free_entries), 64'(6));
      check("flush_valid", 64'(out_valid), 64'(0));
      check("flush_err", 64'(dispatch_err), 64'(1));
      for (int k = 0; k < 600; k++)
         cyc(int'($urandom_range(4)), int'($urandom_range(2)), int'($urandom_range(15) == 0),
             100 + 4 * k, int'($urandom_range(63) == 0));
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      check("end_rst_err", 64'(dispatch_err), 64'(0));
      check("end_rst_empty", 64'(empty), 64'(1));
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
